ecc32_encode_stage: RTL and testbench

Pipelined check-bit generator for 32-bit data words. It sits directly upstream of the 32-bit single-error-correcting decoder/corrector and produces the 8 check bits that decoder expects, so a clean word yields an all-zero syndrome. The block has a valid/ready streaming interface and a 2-entry output buffer. It also supports one-shot error injection, so the downstream corrector can be exercised in-system.

---
 rtl/ecc32_pkg.sv | 16 +
 rtl/ecc32_fifo2.sv | 34 +++
 rtl/ecc32_encode_stage.sv | 62 ++++++
 tb/tb_ecc32_encode_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ecc32_pkg.sv
// ecc32_pkg: shared widths, check-bit masks, encoder function and injection state type
package ecc32_pkg;
   localparam int DATA_W = 32;
   localparam int CHK_W = 8;
   localparam logic [DATA_W-1:0] MASK [0:CHK_W-1] = '{
      32'h00FF1111, 32'hFF002222, 32'h0F0F4444, 32'hF0F08888,
      32'h111100FF, 32'h2222FF00, 32'h44440F0F, 32'h8888F0F0
   };
   typedef enum logic {INJ_IDLE, INJ_ARMED} inj_state_t;
   function automatic logic [CHK_W-1:0] ecc32_chk(input logic [DATA_W-1:0] data);
      logic [CHK_W-1:0] c;
      c = '0;
      for (int i = 0; i < CHK_W; i++) c[i] = ^(data & MASK[i]);
      return c;
   endfunction
endpackage

// File: rtl/ecc32_fifo2.sv
// ecc32_fifo2: 2-entry register FIFO, head always presented on dout
module ecc32_fifo2 #(
   parameter int W = 40
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   logic [W-1:0] e0, e1;
   logic [1:0]   cnt;
   logic         wa;
   assign full  = cnt == 2'd2;
   assign empty = cnt == 2'd0;
   assign dout  = e0;
   // a push lands in the slot left after any simultaneous pop has shifted the queue
   assign wa    = (cnt - {1'b0, pop}) == 2'd1;
   // shift on pop, then write the new entry; the write wins over the shift on e0
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         e0  <= '0;
         e1  <= '0;
         cnt <= '0;
      end else begin
         if (pop) e0 <= e1;
         if (push && !wa) e0 <= din;
         if (push && wa) e1 <= din;
         cnt <= cnt + {1'b0, push} - {1'b0, pop};
      end
endmodule

// File: rtl/ecc32_encode_stage.sv
// ecc32_encode_stage: check-bit encoder with 2-entry output buffer, error injection and word counter
module ecc32_encode_stage
   import ecc32_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [31:0]       in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [31:0]       out_data,
   output logic [7:0]        out_chk,
   output logic              out_en,
   input  logic              out_ready,
   input  logic              inj_req,
   input  logic [39:0]       inj_mask,
   output logic              inj_busy,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  word_cnt
);
   inj_state_t  state;
   logic [39:0] mask;
   logic [39:0] enc;
   logic [39:0] din;
   logic        full, empty, push, pop;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign enc       = {ecc32_chk(in_data), in_data};
   assign din       = (state == INJ_ARMED) ? enc ^ mask : enc;
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign out_en    = out_valid;
   assign inj_busy  = state == INJ_ARMED;
   ecc32_fifo2 #(.W(40)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   (din),
      .dout  ({out_chk, out_data}),
      .full  (full),
      .empty (empty)
   );
   // arm on a request while idle; the armed mask is consumed by the next push
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= INJ_IDLE;
         mask  <= '0;
      end else if (state == INJ_IDLE && inj_req) begin
         state <= INJ_ARMED;
         mask  <= inj_mask;
      end else if (state == INJ_ARMED && push) begin
         state <= INJ_IDLE;
      end
   // saturating count of output handshakes, clear takes priority
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) word_cnt <= '0;
      else if (cnt_clr) word_cnt <= '0;
      else if (pop && !(&word_cnt)) word_cnt <= word_cnt + 1'b1;
endmodule

// File: tb/tb_ecc32_encode_stage.sv
// tb_ecc32_encode_stage: scoreboard bench for the check-bit encode stage
module tb_ecc32_encode_stage;
   logic        clk = 0;
   logic        rst_n = 0;
   logic        in_valid = 0;
   logic [31:0] in_data = 0;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic [7:0]  out_chk;
   logic        out_en;
   logic        out_ready = 0;
   logic        inj_req = 0;
   logic [39:0] inj_mask = 0;
   logic        inj_busy;
   logic        cnt_clr = 0;
   logic [3:0]  word_cnt;
   int          total = 0;
   int          bad = 0;
   logic [39:0] q[$];
   logic [39:0] exp_w;
   logic [31:0] tm [0:7] = '{
      32'h00FF1111, 32'hFF002222, 32'h0F0F4444, 32'hF0F08888,
      32'h111100FF, 32'h2222FF00, 32'h44440F0F, 32'h8888F0F0
   };

   ecc32_encode_stage #(.CNT_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_chk   (out_chk),
      .out_en    (out_en),
      .out_ready (out_ready),
      .inj_req   (inj_req),
      .inj_mask  (inj_mask),
      .inj_busy  (inj_busy),
      .cnt_clr   (cnt_clr),
      .word_cnt  (word_cnt)
   );

   always #5 clk = ~clk;

   // decoder-side syndrome: recomputed check bits XOR received check bits
   function automatic logic [7:0] syn(input logic [39:0] w);
      logic [7:0] s;
      for (int i = 0; i < 8; i++) s[i] = ^(w[31:0] & tm[i]) ^ w[32+i];
      return s;
   endfunction

   task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic send(input logic [31:0] d, input logic [39:0] e);
      int n = 0;
      in_valid = 1;
      in_data = d;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL send_timeout: got in_ready=0 want 1");
      end else q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d left want 0", q.size());
         q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   // monitor: every output handshake pops the scoreboard and is checked
   always @(negedge clk)
      if (rst_n && out_valid && out_ready) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word: got %h want none", {out_chk, out_data});
         end else begin
            exp_w = q.pop_front();
            chk("word", {out_chk, out_data}, exp_w);
            chk("syndrome", 40'(syn({out_chk, out_data})), 40'(syn(exp_w)));
         end
      end

   initial begin
      #12;
      chk("rst_out_valid", 40'(out_valid), 40'd0);
      chk("rst_out_en", 40'(out_en), 40'd0);
      chk("rst_out_word", {out_chk, out_data}, 40'd0);
      chk("rst_in_ready", 40'(in_ready), 40'd1);
      chk("rst_inj_busy", 40'(inj_busy), 40'd0);
      chk("rst_word_cnt", 40'(word_cnt), 40'd0);
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;
      // encoding vectors
      out_ready = 1;
      send(32'h00000000, 40'h00_00000000);
      send(32'h00000001, 40'h51_00000001);
      send(32'h80000000, 40'h8A_80000000);
      send(32'hFFFFFFFF, 40'h00_FFFFFFFF);
      drain();
      chk("cnt_after_enc", 40'(word_cnt), 40'd4);
      // backpressure
      out_ready = 0;
      send(32'h00000001, 40'h51_00000001);
      send(32'h80000000, 40'h8A_80000000);
      fork
         send(32'h80000001, 40'hDB_80000001);
         begin
            repeat (2) @(posedge clk);
            #1;
            chk("bp_in_ready", 40'(in_ready), 40'd0);
            chk("bp_head", {out_chk, out_data}, 40'h51_00000001);
            chk("bp_out_en", 40'(out_en), 40'd1);
            out_ready = 1;
         end
      join
      drain();
      // injection on data bit 0
      inj_mask = 40'h00_00000001;
      inj_req = 1;
      @(posedge clk);
      #1;
      inj_req = 0;
      chk("inj_busy_armed", 40'(inj_busy), 40'd1);
      send(32'h00000000, 40'h00_00000001);
      chk("inj_busy_done", 40'(inj_busy), 40'd0);
      send(32'h00000000, 40'h00_00000000);
      drain();
      // request and push together: this word clean, next corrupted on chk bit 0
      inj_mask = 40'h01_00000000;
      inj_req = 1;
      send(32'h00000000, 40'h00_00000000);
      inj_req = 0;
      chk("inj_busy_sim", 40'(inj_busy), 40'd1);
      send(32'h00000001, 40'h50_00000001);
      drain();
      chk("inj_busy_sim_done", 40'(inj_busy), 40'd0);
      // counter clear, count, clear together with pop
      cnt_clr = 1;
      @(posedge clk);
      #1;
      cnt_clr = 0;
      chk("cnt_clr", 40'(word_cnt), 40'd0);
      send(32'h80000000, 40'h8A_80000000);
      send(32'hFFFFFFFF, 40'h00_FFFFFFFF);
      drain();
      chk("cnt_two", 40'(word_cnt), 40'd2);
      out_ready = 0;
      send(32'h00000001, 40'h51_00000001);
      cnt_clr = 1;
      out_ready = 1;
      @(posedge clk);
      #1;
      cnt_clr = 0;
      chk("cnt_clr_pop", 40'(word_cnt), 40'd0);
      chk("clr_pop_emptied", 40'(out_valid), 40'd0);
      // saturation
      for (int i = 0; i < 20; i++) begin
         if (i[0]) send(32'hFFFFFFFF, 40'h00_FFFFFFFF);
         else send(32'h00000000, 40'h00_00000000);
      end
      drain();
      chk("cnt_sat", 40'(word_cnt), 40'hF);
      // reset mid-operation
      out_ready = 0;
      send(32'h00000001, 40'h51_00000001);
      send(32'h80000000, 40'h8A_80000000);
      inj_mask = 40'hFF_FFFFFFFF;
      inj_req = 1;
      @(posedge clk);
      #1;
      inj_req = 0;
      chk("pre_rst_busy", 40'(inj_busy), 40'd1);
      chk("pre_rst_full", 40'(in_ready), 40'd0);
      #2;
      rst_n = 0;
      #1;
      chk("mid_rst_valid", 40'(out_valid), 40'd0);
      chk("mid_rst_busy", 40'(inj_busy), 40'd0);
      q.delete();
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;
      chk("post_rst_ready", 40'(in_ready), 40'd1);
      chk("post_rst_cnt", 40'(word_cnt), 40'd0);
      out_ready = 1;
      send(32'h00000000, 40'h00_00000000);
      drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
